// File: rtl/truth_table_checker_pkg.sv
// truth_table_checker_pkg: shared FSM encoding, limits and course-gate truth tables
package truth_table_checker_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINISH} tt_state_e;
   localparam int TT_MAX_IN = 4;
   localparam logic [3:0] TT_A_OR_NOTB = 4'b1101;
   localparam logic [3:0] TT_AND = 4'b1000;
   localparam logic [3:0] TT_OR = 4'b1110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_XOR = 4'b0110;
endpackage

// File: rtl/truth_table_checker_sequencer.sv
// tt_vector_sequencer: walks stim through every input vector, holding each for SETTLE cycles
module tt_vector_sequencer #(
   parameter int N_IN = 2,
   parameter int SETTLE = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   output logic [N_IN-1:0] stim,
   output logic            sample,
   output logic            last
);
   localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
   logic [N_IN-1:0] stim_q, stim_d;
   logic [CW-1:0] cnt_q, cnt_d;
   assign stim = stim_q;
   assign sample = run && cnt_q == CW'(SETTLE - 1);
   assign last = sample && stim_q == {N_IN{1'b1}};
   // stim holds on the final row so it stays visible while the result is reported
   always_comb begin
      stim_d = !run ? '0 : (sample && !last) ? stim_q + 1'b1 : stim_q;
      cnt_d = (!run || sample) ? '0 : cnt_q + 1'b1;
   end
   // vector and settle counters
   always_ff @(posedge clk) begin
      if (reset) begin
         stim_q <= '0;
         cnt_q <= '0;
      end else begin
         stim_q <= stim_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/truth_table_checker.sv
// truth_table_checker: exhaustive self-checking walk of a small combinational gate; failing-row map built only with TT_CHECKER_FAILMAP_EN
module truth_table_checker
   import truth_table_checker_pkg::*;
#(
   parameter int N_IN = 2,
   parameter logic [(1<<N_IN)-1:0] EXPECT = TT_A_OR_NOTB,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 resp,
   output logic [N_IN-1:0]      stim,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_count,
   output logic [(1<<N_IN)-1:0] fail_map
);
   tt_state_e state_q, state_d;
   logic [N_IN:0] err_count_q, err_count_d;
   logic pass_q, pass_d;
   logic sample, last, mism;
   tt_vector_sequencer #(.N_IN(N_IN), .SETTLE(SETTLE)) u_seq (
      .clk(clk),
      .reset(reset),
      .run(state_q == ST_RUN),
      .stim(stim),
      .sample(sample),
      .last(last)
   );
   assign mism = sample && (resp != EXPECT[stim]);
   assign busy = state_q == ST_RUN;
   assign done = state_q == ST_FINISH;
   assign pass = pass_q;
   assign err_count = err_count_q;
   // run control and result accumulation; the last row's mismatch counts toward pass
   always_comb begin
      state_d = state_q;
      err_count_d = err_count_q;
      pass_d = pass_q;
      case (state_q)
         ST_IDLE: if (start) begin
            state_d = ST_RUN;
            err_count_d = '0;
            pass_d = 1'b0;
         end
         ST_RUN: if (sample) begin
            err_count_d = mism ? err_count_q + 1'b1 : err_count_q;
            state_d = last ? ST_FINISH : ST_RUN;
            pass_d = last ? (!mism && err_count_q == '0) : pass_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   // state and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         err_count_q <= '0;
         pass_q <= 1'b0;
      end else begin
         state_q <= state_d;
         err_count_q <= err_count_d;
         pass_q <= pass_d;
      end
   end
`ifdef TT_CHECKER_FAILMAP_EN
   logic [(1<<N_IN)-1:0] fail_map_q, fail_map_d;
   assign fail_map = fail_map_q;
   // mark each mismatching row; cleared when a run is accepted
   always_comb begin
      fail_map_d = fail_map_q;
      if (state_q == ST_IDLE && start) fail_map_d = '0;
      if (mism) fail_map_d[stim] = 1'b1;
   end
   // failing-row bitmap register
   always_ff @(posedge clk) begin
      if (reset) fail_map_q <= '0;
      else fail_map_q <= fail_map_d;
   end
`else
   assign fail_map = '0;
`endif
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: randomized and directed checks of truth_table_checker against a row-by-row model
module tb_truth_table_checker;
   logic clk = 0, reset = 1, start1 = 0, start3 = 0;
   logic resp1, resp3, busy1, busy3, done1, done3, pass1, pass3;
   logic [1:0] stim1, stim3;
   logic [2:0] err1, err3;
   logic [3:0] map1, map3;
   int mode = 0;
   logic [3:0] rt = 4'h0;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;

   function automatic logic gate(input int m, input logic [1:0] s, input logic [3:0] t);
      logic good;
      good = s[1] | ~s[0];
      case (m)
         0: return good;
         1: return 1'b0;
         2: return ~good;
         default: return t[s];
      endcase
   endfunction

   assign resp1 = gate(mode, stim1, rt);
   assign resp3 = gate(mode, stim3, rt);

   truth_table_checker #(.N_IN(2), .EXPECT(4'b1101), .SETTLE(1)) u1 (
      .clk(clk), .reset(reset), .start(start1), .resp(resp1), .stim(stim1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_map(map1));
   truth_table_checker #(.N_IN(2), .EXPECT(4'b1101), .SETTLE(3)) u3 (
      .clk(clk), .reset(reset), .start(start3), .resp(resp3), .stim(stim3),
      .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_map(map3));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model(input int m, input logic [3:0] t, output logic [2:0] e_err, output logic [3:0] e_map);
      logic [1:0] s;
      e_err = 0;
      e_map = 0;
      for (int k = 0; k < 4; k++) begin
         s = 2'(k);
         if (gate(m, s, t) != (s[1] | ~s[0])) begin
            e_err = e_err + 1;
            e_map[k] = 1'b1;
         end
      end
`ifndef TT_CHECKER_FAILMAP_EN
      e_map = 0;
`endif
   endtask

   task automatic run1(input string name, input int m, input logic [3:0] t, input int restart_at);
      logic [2:0] e_err;
      logic [3:0] e_map;
      mode = m;
      rt = t;
      model(m, t, e_err, e_map);
      start1 = 1;
      tick;
      start1 = 0;
      checks++;
      if (busy1 !== 1 || stim1 !== 0 || err1 !== 0 || pass1 !== 0 || done1 !== 0) begin
         errors++;
         $display("FAIL %s start: busy=%b stim=%0d err=%0d pass=%b done=%b expected 1 0 0 0 0", name, busy1, stim1, err1, pass1, done1);
      end
      for (int i = 1; i <= 4; i++) begin
         start1 = (i == restart_at);
         tick;
         start1 = 0;
         checks++;
         if (i < 4) begin
            if (busy1 !== 1 || done1 !== 0 || stim1 !== 2'(i)) begin
               errors++;
               $display("FAIL %s walk%0d: busy=%b done=%b stim=%0d expected 1 0 %0d", name, i, busy1, done1, stim1, i);
            end
         end else if (done1 !== 1 || busy1 !== 0 || pass1 !== (e_err == 0) || err1 !== e_err || map1 !== e_map) begin
            errors++;
            $display("FAIL %s result: done=%b busy=%b pass=%b err=%0d map=%b expected 1 0 %b %0d %b", name, done1, busy1, pass1, err1, map1, e_err == 0, e_err, e_map);
         end
      end
      tick;
      checks++;
      if (done1 !== 0 || busy1 !== 0 || stim1 !== 0 || err1 !== e_err || pass1 !== (e_err == 0)) begin
         errors++;
         $display("FAIL %s idle: done=%b busy=%b stim=%0d err=%0d pass=%b expected 0 0 0 %0d %b", name, done1, busy1, stim1, err1, pass1, e_err, e_err == 0);
      end
   endtask

   task automatic test_reset;
      reset = 1;
      tick;
      tick;
      reset = 0;
      checks++;
      if (busy1 !== 0 || done1 !== 0 || pass1 !== 0 || err1 !== 0 || stim1 !== 0 || map1 !== 0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b pass=%b err=%0d stim=%0d map=%b expected all 0", busy1, done1, pass1, err1, stim1, map1);
      end
   endtask

   task automatic test_gates;
      run1("correct", 0, 4'h0, -1);
      run1("stuck0", 1, 4'h0, -1);
      run1("inverted", 2, 4'h0, -1);
      for (int r = 0; r < 6; r++) run1("random", 3, 4'($urandom_range(0, 15)), -1);
   endtask

   task automatic test_settle3;
      mode = 0;
      start3 = 1;
      tick;
      start3 = 0;
      for (int i = 1; i <= 12; i++) begin
         tick;
         checks++;
         if (i < 12) begin
            if (busy3 !== 1 || done3 !== 0 || stim3 !== 2'(i / 3)) begin
               errors++;
               $display("FAIL settle3 walk%0d: busy=%b done=%b stim=%0d expected 1 0 %0d", i, busy3, done3, stim3, i / 3);
            end
         end else if (done3 !== 1 || pass3 !== 1 || err3 !== 0 || map3 !== 0) begin
            errors++;
            $display("FAIL settle3 result: done=%b pass=%b err=%0d map=%b expected 1 1 0 0000", done3, pass3, err3, map3);
         end
      end
      tick;
      checks++;
      if (done3 !== 0 || busy3 !== 0) begin
         errors++;
         $display("FAIL settle3 idle: done=%b busy=%b expected 0 0", done3, busy3);
      end
   endtask

   task automatic test_back_to_back;
      run1("ignore_start", 1, 4'h0, 2);
      run1("b2b", 0, 4'h0, -1);
      run1("b2b_inv", 2, 4'h0, -1);
   endtask

   task automatic test_mid_reset;
      mode = 1;
      start1 = 1;
      tick;
      start1 = 0;
      tick;
      reset = 1;
      tick;
      reset = 0;
      checks++;
      if (busy1 !== 0 || stim1 !== 0 || err1 !== 0 || done1 !== 0 || pass1 !== 0) begin
         errors++;
         $display("FAIL mid_reset: busy=%b stim=%0d err=%0d done=%b pass=%b expected 0 0 0 0 0", busy1, stim1, err1, done1, pass1);
      end
      for (int i = 0; i < 5; i++) begin
         tick;
         checks++;
         if (done1 !== 0 || busy1 !== 0) begin
            errors++;
            $display("FAIL mid_reset_nodone%0d: done=%b busy=%b expected 0 0", i, done1, busy1);
         end
      end
   endtask

   initial begin
      test_reset;
      test_gates;
      test_settle3;
      test_back_to_back;
      test_mid_reset;
      run1("after_reset", 2, 4'h0, -1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Sequential exhaustive checker for small combinational gate modules, such as the two-input gate exercises in this course set. On `start` it drives every input vector 0 … 2^N_IN−1 onto `stim` and samples the gate's `resp` after a settle interval. Each sample is compared with a parameterised expected truth table, and the block reports a mismatch count and pass/fail. It sits beside the gate under test and replaces the manual `$monitor` walk-through with a self-checking result.

## Interface
Parameters:
- `N_IN`, 2, number of gate inputs (1–4).
- `EXPECT`, 4'b1101, expected output per row. Bit k is the expected `resp` for `stim == k`, with the MSB of `stim` as the first input. The default encodes `s = a | ~b` with `stim = {a,b}`.
- `SETTLE`, 1, number of cycles each vector is held before `resp` is sampled (≥1).

Ports:
- `clk`, in, 1: the single clock. All state changes on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: run request, accepted only in IDLE.
- `resp`, in, 1: output of the gate under test.
- `stim`, out, N_IN: input vector driven to the gate.
- `busy`, out, 1: high while a run is in progress.
- `done`, out, 1: one-cycle pulse when a run ends.
- `pass`, out, 1: result of the last run (1 = zero mismatches).
- `err_count`, out, N_IN+1: number of mismatching rows in the last or current run.
- `fail_map`, out, 2^N_IN: failing-row bitmap (see Configuration).

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - RUN: hold `stim`, count settle cycles.
  - FINISH: `done`=1 for one cycle, then IDLE.
- IDLE → RUN:
  - Requires `start`=1.
  - Sets `stim`=0, settle count=0, `err_count`=0, `fail_map`=0, `pass`=0.
- RUN, settle count < SETTLE−1: increment the settle count.
- RUN, settle count == SETTLE−1 (sample edge):
  - Compare `resp` with `EXPECT[stim]`.
  - On mismatch, increment `err_count` and set `fail_map[stim]`.
  - If `stim` == 2^N_IN−1, go to FINISH and set `pass` = (final error count == 0), including a mismatch on this last row.
  - Otherwise increment `stim` and clear the settle count.
- FINISH → IDLE unconditionally. `stim` returns to 0 and `err_count`/`pass`/`fail_map` hold until the next accepted `start`.
- `start` in RUN or FINISH is ignored (no restart, no queueing).
- `err_count` width N_IN+1 covers the worst case of 2^N_IN mismatches without wrap.

## Timing
- Reset values: `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_map`=0; state IDLE.
- `start` sampled high at edge t0 → `busy`=1 and `stim`=0 from t0.
- Each vector is held exactly SETTLE cycles. `resp` is sampled on the last edge of that window, so the gate sees a stable input for SETTLE cycles.
- The last sample is at edge t0 + 2^N_IN·SETTLE. From that edge `busy`=0 and `done`=1 for one cycle, with `pass` valid.
- A back-to-back `start` is accepted on the edge where the FSM is in IDLE again, i.e. the edge after `done`.
- `reset` mid-run: the next edge returns to IDLE with all reset values. No `done` pulse; the partial result is discarded.

## Configuration
- Macro `TT_CHECKER_FAILMAP_EN`.
- Defined: `fail_map` register implemented as described in Operation.
- Undefined:
  - `fail_map` tied to 0 and no storage is built.
  - `err_count`, `pass` and timing are unchanged.

## Structure
- Shared package holds:
  - FSM state encodings (IDLE, RUN, FINISH).
  - `TT_MAX_IN` = 4.
  - Default `EXPECT` constants for the course gates (e.g. `TT_A_OR_NOTB` = 4'b1101).
- One sub-module, `tt_vector_sequencer`: holds the `stim` counter and settle counter, and produces `sample` and `last` strobes.
- The top level keeps the FSM, the comparison and the result registers.

## Test plan
- Correct gate model (`resp = stim[1] | ~stim[0]`), SETTLE=1:
  - `done` at t0+4, `pass`=1, `err_count`=0, `fail_map`=4'b0000.
- `resp` stuck at 0:
  - `err_count`=3, `pass`=0.
  - With macro: `fail_map`=4'b1101. Without macro: `fail_map`=0.
- SETTLE=3 with a correct model:
  - Each `stim` value is held 3 cycles (0,0,0,1,1,1,…).
  - `done` at t0+12, `pass`=1.
- `start` pulsed again at t0+2 during a run:
  - Ignored; a single `done` at t0+4.
  - Then `start` on the cycle after `done` is accepted and restarts with `err_count`=0.
- `reset` asserted at t0+2:
  - At the next edge `busy`=0, `stim`=0, `err_count`=0; no `done` pulse.
- `resp` = inverted correct model (all rows wrong):
  - `err_count`=4 (no wrap in 3 bits), `pass`=0.
  - With macro: `fail_map`=4'b1111.
